// File: rtl/fusion_vout_timing.sv
// Fusion output timing stage: buffers the bursty fusion pixel stream
// and re-emits it as a DE/HSYNC/VSYNC raster on clk_ch2.
module fusion_vout_timing #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int FIFO_DEPTH = 2048,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1
) (
  input  logic                          clk_ch2,
  input  logic                          rst_n,
  input  logic [23:0]                   fusion_data,
  input  logic                          fusion_valid,
  input  logic                          err_clr,
  output logic [23:0]                   vout_data,
  output logic                          vout_de,
  output logic                          vout_hs,
  output logic                          vout_vs,
  output logic                          underflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_END = HW'(HT - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_END = VW'(VT - 1);
  localparam logic [AW:0]   PRIME = (AW+1)'(H_ACTIVE);
  localparam logic [AW:0]   FULLV = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] h_cnt, h_nx;
  logic [VW-1:0] v_cnt, v_nx;
  logic          frame_bad, bad_nx;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic          full, empty, wr_en, rd_en;
  logic          run, de_n, hs_n, vs_n;
  logic [23:0]   head;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == FULLV);
  assign empty      = (level == '0);
  assign fifo_level = level;
  assign head       = mem[rd_ptr[AW-1:0]];

  assign run   = (state == RUN);
  assign de_n  = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n  = run && (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_n  = run && (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign wr_en = fusion_valid && !full;
  assign rd_en = de_n && !empty;

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk_ch2) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= fusion_data;
  end

  // FIFO pointers; reset empties the buffer
  always_ff @(posedge clk_ch2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Raster state and counters
  always_ff @(posedge clk_ch2 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_nx;
      h_cnt     <= h_nx;
      v_cnt     <= v_nx;
      frame_bad <= bad_nx;
    end
  end

  // Next state: prime a line, then free-run; a bad frame resyncs at its end
  always_comb begin
    state_nx = state;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    bad_nx   = frame_bad;
    unique case (state)
      IDLE: begin
        h_nx   = '0;
        v_nx   = '0;
        bad_nx = 1'b0;
        if (level >= PRIME) state_nx = RUN;
      end
      RUN: begin
        if (de_n && empty) bad_nx = 1'b1;
        if (h_cnt == H_END) begin
          h_nx = '0;
          if (v_cnt == V_END) begin
            v_nx = '0;
            if (frame_bad) begin
              state_nx = IDLE;
              bad_nx   = 1'b0;
            end
          end else begin
            v_nx = v_cnt + VW'(1);
          end
        end else begin
          h_nx = h_cnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered video outputs, one clock behind the counters
  always_ff @(posedge clk_ch2 or negedge rst_n) begin
    if (!rst_n) begin
      vout_data <= '0;
      vout_de   <= 1'b0;
      vout_hs   <= !HS_POL;
      vout_vs   <= !VS_POL;
    end else begin
      vout_data <= rd_en ? head : '0;
      vout_de   <= de_n;
      vout_hs   <= hs_n ? HS_POL : !HS_POL;
      vout_vs   <= vs_n ? VS_POL : !VS_POL;
    end
  end

  // Sticky error flags; a new event wins over a clear
  always_ff @(posedge clk_ch2 or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (de_n && empty)       underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
      if (fusion_valid && full) overflow <= 1'b1;
      else if (err_clr)         overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fusion_vout_timing.sv
// Bench for fusion_vout_timing: random pixels against a queue-based
// raster model, directed phases for priming, errors and reset.
module tb_fusion_vout_timing;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int DEPTH = 16;
  localparam bit HPOL = 1'b1, VPOL = 1'b1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic        clk_ch2 = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] fusion_data = '0;
  logic        fusion_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [23:0] vout_data;
  logic        vout_de, vout_hs, vout_vs;
  logic        underflow, overflow;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  logic [23:0] q[$];
  int          pos;
  bit          m_run, m_bad;
  logic [23:0] e_data;
  logic        e_de, e_hs, e_vs, e_uf, e_of;

  fusion_vout_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FIFO_DEPTH(DEPTH), .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .clk_ch2(clk_ch2), .rst_n(rst_n),
    .fusion_data(fusion_data), .fusion_valid(fusion_valid),
    .err_clr(err_clr),
    .vout_data(vout_data), .vout_de(vout_de),
    .vout_hs(vout_hs), .vout_vs(vout_vs),
    .underflow(underflow), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk_ch2 = ~clk_ch2;

  function automatic bit cur_de();
    return m_run && (pos % HT) < HA && (pos / HT) < VA;
  endfunction

  task automatic model_reset();
    q.delete();
    pos = 0; m_run = 0; m_bad = 0;
    e_data = '0; e_de = 0; e_hs = !HPOL; e_vs = !VPOL;
    e_uf = 0; e_of = 0;
  endtask

  task automatic model_edge(input logic v, input logic [23:0] d,
                            input logic c);
    int h, ln, lvl;
    bit de, hs, vs, full, empty;
    h = pos % HT; ln = pos / HT; lvl = q.size();
    de = cur_de();
    hs = m_run && h >= HA + HFP && h < HA + HFP + HSY;
    vs = m_run && ln >= VA + VFP && ln < VA + VFP + VSY;
    full = (lvl == DEPTH); empty = (lvl == 0);
    e_de = de;
    e_hs = hs ? HPOL : !HPOL;
    e_vs = vs ? VPOL : !VPOL;
    e_data = (de && !empty) ? q[0] : 24'h0;
    if (de && empty) e_uf = 1; else if (c) e_uf = 0;
    if (v && full) e_of = 1; else if (c) e_of = 0;
    if (de && !empty) void'(q.pop_front());
    if (v && !full) q.push_back(d);
    if (!m_run) begin
      pos = 0;
      if (lvl >= HA) m_run = 1;
    end else begin
      if (de && empty) m_bad = 1;
      if (pos == FT - 1) begin
        pos = 0;
        if (m_bad) begin m_run = 0; m_bad = 0; end
      end else pos++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, 32'(vout_data), 32'(e_data));
    chk({tag, ".de"}, 32'(vout_de), 32'(e_de));
    chk({tag, ".hs"}, 32'(vout_hs), 32'(e_hs));
    chk({tag, ".vs"}, 32'(vout_vs), 32'(e_vs));
    chk({tag, ".uf"}, 32'(underflow), 32'(e_uf));
    chk({tag, ".of"}, 32'(overflow), 32'(e_of));
    chk({tag, ".lvl"}, 32'(fifo_level), 32'(q.size()));
  endtask

  task automatic step(input string tag, input logic v,
                      input logic c);
    logic [23:0] d;
    d = 24'($urandom);
    fusion_valid = v; fusion_data = d; err_clr = c;
    @(posedge clk_ch2);
    model_edge(v, d, c);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int n;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_ch2);
    #1 chk_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) step("prime7", 1'b1, 1'b0);
    step("prime8", 1'b1, 1'b0);
    step("start", 1'b0, 1'b0);
    step("first_px", cur_de(), 1'b0);

    for (int i = 0; i < 2 * FT; i++) step("steady", cur_de(), 1'b0);

    n = 0;
    while (!(pos / HT >= VA && pos % HT == 0) && n < 2 * FT) begin
      step("to_vblank", cur_de(), 1'b0);
      n++;
    end
    for (int i = 0; i < 17; i++) step("ovf", 1'b1, i == 16);
    for (int i = 0; i < FT; i++) step("post_ovf", cur_de(), 1'b0);
    step("clr_ovf", 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step("steady2", cur_de(), 1'b0);

    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("rst_mid");
    @(posedge clk_ch2);
    #1 chk_all("rst_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step("reprime", 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 3 * FT && (m_run || n == 0); i++) begin
      step("udf", cur_de() && n < 4, 1'b0);
      if (cur_de()) n++;
    end
    step("udf_idle", 1'b0, 1'b0);
    step("clr_udf", 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
    for (int i = 0; i < 40; i++)
      step("rand_mix", cur_de() || ($urandom_range(0, 3) == 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fusion_vout_timing.md
Name: fusion_vout_timing

Overview:
- Downstream stage of the two-channel fusion block, clocked on clk_ch2.
- Buffers the bursty fusion_data/fusion_valid pixel stream in an internal FIFO.
- Re-emits the pixels as a continuous raster with DE/HSYNC/VSYNC timing for the display/encoder interface.
- Primes one full line before starting, and reports underflow and overflow.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width (clocks)
H_BP, 220, horizontal back porch (clocks)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
FIFO_DEPTH, 2048, internal FIFO entries; power of 2, >= H_ACTIVE
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
clk_ch2  in  1  pixel clock (same domain as fusion output)
rst_n  in  1  asynchronous active-low reset
fusion_data  in  24  RGB888 pixel {R,G,B} from fusion stage
fusion_valid  in  1  pixel strobe; one pixel per high cycle
err_clr  in  1  synchronous pulse; clears sticky error flags
vout_data  out  24  output pixel; 0 outside active area and on underflow
vout_de  out  1  data enable
vout_hs  out  1  horizontal sync, level per HS_POL
vout_vs  out  1  vertical sync, level per VS_POL
underflow  out  1  sticky: active pixel requested while FIFO empty
overflow  out  1  sticky: fusion_valid while FIFO full (pixel dropped)
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is clk_ch2.
  - Under reset: state IDLE, FIFO empty, h_cnt=v_cnt=0.
  - Outputs: vout_data=0, vout_de=0, vout_hs=~HS_POL, vout_vs=~VS_POL, underflow=0, overflow=0, fifo_level=0.
- FIFO: synchronous, show-ahead (head word visible while not empty).
  - Write when fusion_valid && !full.
  - fusion_valid && full: pixel dropped, overflow<=1. Full is evaluated before any same-cycle read.
  - Simultaneous write and read: level unchanged.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, FP, sync, BP. Frame order is the same in lines.
- FSM state IDLE:
  - Counters held at 0; outputs at their idle/reset values.
  - Go to RUN at the next edge when fifo_level >= H_ACTIVE.
- FSM state RUN:
  - h_cnt increments every clock; wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0.
- Per-cycle decodes from the counters:
  - de_n = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs_n active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_n active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; vs changes only when h_cnt=0.
- Read path:
  - rd_en = de_n && !empty.
  - Registered outputs: vout_de<=de_n, vout_hs/vs<=decode, vout_data <= rd_en ? head : 0.
  - Latency is 1 clock from the counter state to the outputs.
  - The first vout_de=1 appears one clock after the IDLE->RUN edge.
- Underflow: de_n && empty gives vout_data=0 with vout_de still 1, underflow<=1, and sets the internal frame_bad flag.
- Resync: frame_bad at the v_cnt wrap (V_TOTAL-1 -> 0 with h_cnt wrap) sends the FSM to IDLE.
  - The FIFO is not flushed.
  - frame_bad clears on entering IDLE.
- err_clr clears underflow/overflow. If an error event occurs in the same cycle, set wins.
- Reset mid-frame aborts immediately. The FIFO is emptied and resumes from IDLE priming.

Test Plan (params H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1,FIFO_DEPTH=16):
- Reset: assert rst_n=0 mid-run -> all outputs at reset values the same cycle; fifo_level=0 after release.
- Priming: write 7 pixels -> stays IDLE, vout_de=0. Write the 8th -> next edge RUN; vout_de=1 one clock later with vout_data=pixel0.
- Steady stream of 1 pixel/clock during active time:
  - vout_de high 8 clocks per line, for 4 lines.
  - vout_hs active at line clocks 10-11.
  - vout_vs active for line 5 (14 clocks).
  - Pixel order preserved; no errors.
- Underflow: stop writes after 12 pixels -> pixels 12+ output as 0 with vout_de=1, underflow=1; FSM returns to IDLE at frame end; err_clr pulse -> underflow=0.
- Overflow: hold in IDLE-free FIFO and write 17 pixels with no reads -> fifo_level=16, overflow=1, 17th pixel never appears at vout_data.
- Simultaneous write/read during active: fifo_level constant; err_clr together with overflow event -> overflow remains 1.
